// File: rtl/router_pkt_injector.sv
// Packet source for one router input port: takes a packet descriptor and
// serialises it into head/body/tail flits, stalls on the router's fifo_full
// back-pressure, and keeps packet/stall statistics.
module router_pkt_injector #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 4,
    parameter int PORT_W     = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PORT_W-1:0] req_dest,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_seed,
    input  logic              fifo_full,
    output logic              flit_valid,
    output logic              flit_head,
    output logic              flit_tail,
    output logic [PORT_W-1:0] flit_port,
    output logic [DATA_W-1:0] flit_data,
    output logic              busy,
    output logic              err_len,
    output logic [15:0]       pkt_count,
    output logic [15:0]       stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The gap counter is loaded on the tail flit and counts down to zero,
    // so it holds GAP_CYCLES-1 on the first idle cycle after the tail.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t            state;
    state_t            state_nxt;
    logic [PORT_W-1:0] dest_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [DATA_W-1:0] seed_q;
    logic [3:0]        gap_cnt;
    logic              err_len_q;
    logic [15:0]       pkt_cnt_q;
    logic [15:0]       stall_cnt_q;
    logic              hs;
    logic              last_flit;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // State register; reset drops straight back to IDLE so all flit outputs clear at once.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and flit presentation; flit_valid follows same-cycle fifo_full.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        hs         = 1'b0;
        last_flit  = 1'b0;
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        flit_tail  = 1'b0;
        flit_port  = '0;
        flit_data  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                hs        = req_valid;
                if (req_valid && (req_len != '0)) state_nxt = SEND;
            end
            SEND: begin
                last_flit  = (idx_q == (len_q - LEN_W'(1)));
                flit_valid = !fifo_full;
                if (flit_valid) begin
                    flit_head = (idx_q == '0);
                    flit_tail = last_flit;
                    flit_port = dest_q;
                    flit_data = seed_q + DATA_W'(idx_q);
                    if (last_flit) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Descriptor latch on handshake; flit index advances only on a sent flit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dest_q <= '0;
            len_q  <= '0;
            seed_q <= '0;
            idx_q  <= '0;
        end else if (hs) begin
            dest_q <= req_dest;
            len_q  <= req_len;
            seed_q <= req_seed;
            idx_q  <= '0;
        end else if (flit_valid) begin
            idx_q <= idx_q + LEN_W'(1);
        end
    end

    // Post-tail idle countdown.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            gap_cnt <= 4'd0;
        end else if (flit_valid && flit_tail) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
            gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // Zero-length descriptor flag, registered so it pulses the cycle after the handshake.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) err_len_q <= 1'b0;
        else        err_len_q <= hs && (req_len == '0);
    end

    // Saturating packet and stall statistics.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pkt_cnt_q   <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (flit_valid && flit_tail)      pkt_cnt_q   <= sat_inc16(pkt_cnt_q);
            if ((state == SEND) && fifo_full) stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    assign busy        = (state != IDLE);
    assign err_len     = err_len_q;
    assign pkt_count   = pkt_cnt_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_router_pkt_injector.sv
// Bench for router_pkt_injector: two instances (no gap, two-cycle gap) share
// one stimulus stream and are each compared every cycle against a
// packet-level reference model (queue of pending flits plus a gap countdown).
module tb_router_pkt_injector;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;
    localparam int PORT_W = 1;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              req_valid = 1'b0;
    logic [PORT_W-1:0] req_dest = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic [DATA_W-1:0] req_seed = '0;
    logic              fifo_full = 1'b0;

    logic [1:0]        req_ready;
    logic [1:0]        flit_valid;
    logic [1:0]        flit_head;
    logic [1:0]        flit_tail;
    logic [1:0]        busy;
    logic [1:0]        err_len;
    logic [PORT_W-1:0] flit_port [2];
    logic [DATA_W-1:0] flit_data [2];
    logic [15:0]       pkt_count [2];
    logic [15:0]       stall_count [2];

    always #5 clk = ~clk;

    router_pkt_injector #(.DATA_W(DATA_W), .LEN_W(LEN_W), .PORT_W(PORT_W), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_dest(req_dest), .req_len(req_len), .req_seed(req_seed), .fifo_full(fifo_full),
        .flit_valid(flit_valid[0]), .flit_head(flit_head[0]), .flit_tail(flit_tail[0]),
        .flit_port(flit_port[0]), .flit_data(flit_data[0]), .busy(busy[0]), .err_len(err_len[0]),
        .pkt_count(pkt_count[0]), .stall_count(stall_count[0])
    );

    router_pkt_injector #(.DATA_W(DATA_W), .LEN_W(LEN_W), .PORT_W(PORT_W), .GAP_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_dest(req_dest), .req_len(req_len), .req_seed(req_seed), .fifo_full(fifo_full),
        .flit_valid(flit_valid[1]), .flit_head(flit_head[1]), .flit_tail(flit_tail[1]),
        .flit_port(flit_port[1]), .flit_data(flit_data[1]), .busy(busy[1]), .err_len(err_len[1]),
        .pkt_count(pkt_count[1]), .stall_count(stall_count[1])
    );

    // Reference model: one expected-flit queue per instance.
    typedef struct {
        logic [DATA_W-1:0] data;
        logic              head;
        logic              tail;
        logic [PORT_W-1:0] port;
    } flit_t;

    flit_t mq [2][$];
    int    gap_left [2];
    int    gaps [2];
    int    m_pkt [2];
    int    m_stall [2];
    bit    m_err [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            gap_left[d] = 0;
            m_pkt[d]    = 0;
            m_stall[d]  = 0;
            m_err[d]    = 1'b0;
        end
    endtask

    function automatic bit model_idle(input int d);
        return (mq[d].size() == 0) && (gap_left[d] == 0);
    endfunction

    // Compare every output of both instances with what the model predicts now.
    task automatic check_cycle();
        for (int d = 0; d < 2; d++) begin
            flit_t f;
            bit    ev;
            bit    er;
            er     = model_idle(d);
            ev     = (mq[d].size() != 0) && !fifo_full;
            f.data = '0;
            f.head = 1'b0;
            f.tail = 1'b0;
            f.port = '0;
            if (ev) f = mq[d][0];
            chk("flit_valid", d, 32'(flit_valid[d]), 32'(ev));
            chk("flit_head", d, 32'(flit_head[d]), 32'(f.head));
            chk("flit_tail", d, 32'(flit_tail[d]), 32'(f.tail));
            chk("flit_port", d, 32'(flit_port[d]), 32'(f.port));
            chk("flit_data", d, 32'(flit_data[d]), 32'(f.data));
            chk("req_ready", d, 32'(req_ready[d]), 32'(er));
            chk("busy", d, 32'(busy[d]), 32'(!er));
            chk("err_len", d, 32'(err_len[d]), 32'(m_err[d]));
            chk("pkt_count", d, 32'(pkt_count[d]), 32'(m_pkt[d]));
            chk("stall_count", d, 32'(stall_count[d]), 32'(m_stall[d]));
        end
    endtask

    // Advance the model by one clock given the inputs applied this cycle.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            flit_t f;
            bit    hs;
            hs       = req_valid && model_idle(d);
            m_err[d] = hs && (req_len == '0);
            if (mq[d].size() != 0) begin
                if (!fifo_full) begin
                    f = mq[d].pop_front();
                    if (f.tail) begin
                        m_pkt[d]    = (m_pkt[d] == 65535) ? 65535 : m_pkt[d] + 1;
                        gap_left[d] = gaps[d];
                    end
                end else begin
                    m_stall[d] = (m_stall[d] == 65535) ? 65535 : m_stall[d] + 1;
                end
            end else if (gap_left[d] > 0) begin
                gap_left[d]--;
            end
            if (hs && (req_len != '0)) begin
                for (int k = 0; k < int'(req_len); k++) begin
                    f.data = DATA_W'(int'(req_seed) + k);
                    f.head = (k == 0);
                    f.tail = (k == int'(req_len) - 1);
                    f.port = req_dest;
                    mq[d].push_back(f);
                end
            end
        end
    endtask

    // One clock: inputs are already applied just after the previous rising edge.
    task automatic cycle();
        @(negedge clk);
        check_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic settle();
        int guard;
        guard     = 0;
        req_valid = 1'b0;
        fifo_full = 1'b0;
        while (!(model_idle(0) && model_idle(1)) && guard < 64) begin
            cycle();
            guard++;
        end
    endtask

    task automatic send(input logic [PORT_W-1:0] dest, input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] seed);
        req_valid = 1'b1;
        req_dest  = dest;
        req_len   = len;
        req_seed  = seed;
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        gaps[0] = 0;
        gaps[1] = 2;
        model_reset();

        // Reset state
        #2;
        check_cycle();
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Single-flit packet, then directed latency checks on the no-gap instance
        settle();
        send(1'b1, 4'd1, 8'h10);
        chk("t2_valid", 0, 32'(flit_valid[0]), 32'd1);
        chk("t2_headtail", 0, {30'd0, flit_head[0], flit_tail[0]}, 32'd3);
        chk("t2_port", 0, 32'(flit_port[0]), 32'd1);
        chk("t2_data", 0, 32'(flit_data[0]), 32'h10);
        cycle();
        chk("t2_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("t2_pkt", 0, 32'(pkt_count[0]), 32'd1);
        chk("t2_gap_ready", 1, 32'(req_ready[1]), 32'd0);
        settle();

        // Payload wrap
        send(1'b0, 4'd4, 8'hFE);
        settle();

        // Back-pressure for three cycles after the second flit
        send(1'b0, 4'd5, 8'h30);
        run(2);
        fifo_full = 1'b1;
        run(3);
        fifo_full = 1'b0;
        settle();
        chk("t4_stall", 0, 32'(stall_count[0]), 32'd3);
        chk("t4_stall", 1, 32'(stall_count[1]), 32'd3);

        // Zero-length descriptor, then a normal one
        send(1'b0, 4'd0, 8'h55);
        chk("t6_err", 0, 32'(err_len[0]), 32'd1);
        chk("t6_err", 1, 32'(err_len[1]), 32'd1);
        chk("t6_novalid", 0, 32'(flit_valid[0]), 32'd0);
        cycle();
        send(1'b1, 4'd3, 8'hA0);
        settle();

        // Held request stream: back-to-back packets and gap timing
        req_valid = 1'b1;
        req_dest  = 1'b1;
        req_len   = 4'd2;
        req_seed  = 8'h40;
        run(14);
        settle();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_dest  = PORT_W'($urandom_range(0, 1));
            req_len   = LEN_W'($urandom_range(0, 15));
            req_seed  = DATA_W'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            cycle();
        end
        settle();

        // Asynchronous reset in the middle of a packet
        send(1'b1, 4'd8, 8'h77);
        run(3);
        rst_b = 1'b0;
        #2;
        model_reset();
        check_cycle();
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, 4'd3, 8'hC0);
        settle();
        run(2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
